fft_addr_sequencer: RTL and testbench
=====================================

// Module: fft_addr_sequencer
// PURPOSE
//  Control/address sequencer for the in-place radix-2 DIT FFT core (N=256 default).
//  Phases: load samples into working RAM in bit-reversed order; schedule every
//  butterfly (i1, i2, twiddle index) stage by stage; stream the result out.
//  Drives the butterfly RAM ports and the fft_valid output of the FFT top level.
// PARAMETERS
//  N_LOG2    8  log2 of FFT length N (range 2..15)
//  BFLY_LAT  3  butterfly pipeline latency, read issue -> write-back (cycles, >=1)
// PORTS
//  clk        in   1         system clock
//  reset      in   1         synchronous, active-high reset
//  start      in   1         begin a frame (sampled in IDLE only)
//  in_valid   in   1         input sample present on xr_in/xi_in this cycle
//  ld_we      out  1         RAM write enable for input sample
//  ld_addr    out  N_LOG2    bit-reversed load address
//  rd_en      out  1         butterfly operand read strobe
//  i1         out  N_LOG2    upper operand address
//  i2         out  N_LOG2    lower operand address (i1 + span)
//  tw_idx     out  N_LOG2-1  twiddle ROM index
//  wr_en      out  1         butterfly result write strobe
//  wr_i1      out  N_LOG2    write-back address, upper result
//  wr_i2      out  N_LOG2    write-back address, lower result
//  stage_o    out  4         current stage 0..N_LOG2-1
//  out_ready  in   1         downstream accepts output sample
//  fft_valid  out  1         output sample valid; RAM read at out_addr
//  out_addr   out  N_LOG2    natural-order output address
//  busy       out  1         high in any state except IDLE
//  done       out  1         one-cycle pulse after last output accepted
// BEHAVIOUR
//  Reset: state IDLE; every output 0; counters cleared; write-back pipe flushed.
//  Reset mid-frame: same; pending write-backs discarded, no done pulse.
//  Outputs are registered. States: IDLE, LOAD, COMPUTE, DRAIN, UNLOAD.
//  IDLE: start=1 -> LOAD next cycle. start is ignored in all other states.
//  LOAD: per cycle with in_valid=1: ld_we=1, ld_addr=bitrev(cnt), cnt++.
//    in_valid=0 -> ld_we=0, cnt holds. After sample N-1 -> COMPUTE, stage 0.
//    in_valid is ignored outside LOAD.
//  COMPUTE: one butterfly per cycle, b = 0..N/2-1, no stalls. span = 2^s:
//    j = b mod span; i1 = (b>>s)*2*span + j; i2 = i1 + span;
//    tw_idx = j << (N_LOG2-1-s); rd_en=1. After b = N/2-1 -> DRAIN.
//  Write-back: wr_en/wr_i1/wr_i2 are exact copies of rd_en/i1/i2 delayed by
//    BFLY_LAT cycles via a shift pipe.
//  DRAIN: rd_en=0 for exactly BFLY_LAT cycles, so the last write of stage s
//    lands before the first read of stage s+1 (no RAW hazard).
//    Then s<N_LOG2-1 -> s++, COMPUTE; else -> UNLOAD.
//  Cycles per stage = N/2 + BFLY_LAT (1048 total for N=256, BFLY_LAT=3).
//  UNLOAD: fft_valid=1, out_addr starts at 0.
//    out_ready=1 -> out_addr++. out_ready=0 -> out_addr and fft_valid hold.
//    Acceptance of addr N-1 -> IDLE, done=1 for one cycle, fft_valid=0.
//  busy falls in the same cycle done rises. A new start is honoured the
//    following cycle.
//  All counters are N_LOG2 bits wide. Wrap is never reachable because each
//    phase exits at its terminal count.
// TESTING
//  T1 reset: hold reset 3 cycles mid-COMPUTE -> all outputs 0, state IDLE,
//    no wr_en after release.
//  T2 load: start then 256 in_valid pulses with 5 random gaps -> ld_addr
//    sequence 0,128,64,192,...,255; 256 ld_we pulses total.
//  T3 schedule: stage 0 b=0 -> i1=0,i2=1,tw=0; stage 7 b=5 -> i1=5,i2=133,
//    tw=5; stage 3 b=9 -> i1=17,i2=25,tw=16.
//  T4 hazard: BFLY_LAT=3 -> last stage-s wr_en precedes first stage-s+1 rd_en
//    by 1 cycle; 1024 wr_en total.
//  T5 backpressure: out_ready toggled 1/0 -> out_addr 0..255 each exactly once;
//    done pulses once after addr 255 accepted.
//  T6 golden: 256-point impulse at x[0]=0x4000 through full top level ->
//    all fftr equal, ffti=0.

Source files
------------

// File: rtl/fft_addr_sequencer.sv
// fft_addr_sequencer
//   Control and address sequencer for an in-place radix-2 DIT FFT core.
//   A frame goes through four phases:
//     LOAD    - input samples are written to the working RAM in bit-reversed order
//     COMPUTE - one butterfly (i1, i2, twiddle index) is issued per cycle, stage by stage
//     DRAIN   - reads pause for BFLY_LAT cycles so a stage's last write-back lands
//               before the next stage's first read
//     UNLOAD  - the result is streamed out in natural order with valid/ready handshake
//
// Ports
//   clk, reset          system clock, synchronous active-high reset
//   start               begin a frame (only looked at in IDLE)
//   in_valid            input sample present this cycle (only looked at in LOAD)
//   ld_we, ld_addr      RAM write strobe / bit-reversed address for the input sample
//   rd_en, i1, i2       butterfly operand read strobe and addresses
//   tw_idx              twiddle ROM index
//   wr_en, wr_i1, wr_i2 butterfly write-back strobe and addresses (read delayed BFLY_LAT)
//   stage_o             current stage number
//   out_ready           downstream accepts the output sample
//   fft_valid, out_addr output sample valid / natural-order RAM read address
//   busy                high in every state except IDLE
//   done                one-cycle pulse after the last output sample is accepted
//
// All outputs are registered.

module fft_addr_sequencer #(
  parameter int N_LOG2   = 8,
  parameter int BFLY_LAT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              ld_we,
  output logic [N_LOG2-1:0] ld_addr,
  output logic              rd_en,
  output logic [N_LOG2-1:0] i1,
  output logic [N_LOG2-1:0] i2,
  output logic [N_LOG2-2:0] tw_idx,
  output logic              wr_en,
  output logic [N_LOG2-1:0] wr_i1,
  output logic [N_LOG2-1:0] wr_i2,
  output logic [3:0]        stage_o,
  input  logic              out_ready,
  output logic              fft_valid,
  output logic [N_LOG2-1:0] out_addr,
  output logic              busy,
  output logic              done
);

  localparam int N    = 1 << N_LOG2;
  localparam int TW_W = N_LOG2 - 1;
  localparam int DW   = (BFLY_LAT > 1) ? $clog2(BFLY_LAT) : 1;

  localparam logic [N_LOG2-1:0] ONE         = N_LOG2'(1);
  localparam logic [N_LOG2-1:0] LAST_SAMPLE = N_LOG2'(N - 1);
  localparam logic [N_LOG2-1:0] LAST_BFLY   = N_LOG2'(N / 2 - 1);
  localparam logic [3:0]        LAST_STAGE  = 4'(N_LOG2 - 1);
  localparam logic [DW-1:0]     LAST_DRAIN  = DW'(BFLY_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_COMPUTE,
    S_DRAIN,
    S_UNLOAD
  } state_t;

  state_t state_q, state_d;

  logic [N_LOG2-1:0] ld_cnt_q, ld_cnt_d;
  logic [N_LOG2-1:0] bfly_q, bfly_d;
  logic [DW-1:0]     drain_q, drain_d;
  logic [3:0]        stage_q, stage_d;

  logic              ld_we_q, ld_we_d;
  logic [N_LOG2-1:0] ld_addr_q, ld_addr_d;
  logic              rd_en_q, rd_en_d;
  logic [N_LOG2-1:0] i1_q, i1_d;
  logic [N_LOG2-1:0] i2_q, i2_d;
  logic [TW_W-1:0]   tw_q, tw_d;
  logic              fft_valid_q, fft_valid_d;
  logic [N_LOG2-1:0] out_addr_q, out_addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Write-back shift pipe: stage 0 holds the read issued one cycle ago,
  // stage BFLY_LAT-1 is what drives the write port.
  logic              pipe_en_q [BFLY_LAT];
  logic [N_LOG2-1:0] pipe_i1_q [BFLY_LAT];
  logic [N_LOG2-1:0] pipe_i2_q [BFLY_LAT];

  // Bit-reversed load address.
  logic [N_LOG2-1:0] ld_rev;
  genvar gi;
  generate
    for (gi = 0; gi < N_LOG2; gi++) begin : g_bitrev
      assign ld_rev[gi] = ld_cnt_q[N_LOG2-1-gi];
    end
  endgenerate

  // Butterfly address generation for butterfly bfly_q of stage stage_q.
  //   span = 2^s, j = b mod span, i1 = (b >> s) * 2 * span + j,
  //   tw_idx = j << (N_LOG2-1-s). j < 2^s keeps tw_idx inside TW_W bits.
  logic [N_LOG2-1:0] span;
  logic [N_LOG2-1:0] bf_j;
  logic [N_LOG2-1:0] bf_i1;
  logic [N_LOG2-1:0] tw_full;
  logic [3:0]        stage_p1;
  logic [3:0]        tw_shift;

  always_comb begin
    stage_p1 = stage_q + 4'd1;
    tw_shift = LAST_STAGE - stage_q;
    span     = ONE << stage_q;
    bf_j     = bfly_q & (span - ONE);
    bf_i1    = ((bfly_q >> stage_q) << stage_p1) | bf_j;
    tw_full  = bf_j << tw_shift;
  end

  always_comb begin
    state_d     = state_q;
    ld_cnt_d    = ld_cnt_q;
    bfly_d      = bfly_q;
    drain_d     = drain_q;
    stage_d     = stage_q;
    out_addr_d  = out_addr_q;
    ld_we_d     = 1'b0;
    ld_addr_d   = '0;
    rd_en_d     = 1'b0;
    i1_d        = '0;
    i2_d        = '0;
    tw_d        = '0;
    fft_valid_d = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_LOAD;
          ld_cnt_d = '0;
          stage_d  = '0;
        end
      end

      S_LOAD: begin
        if (in_valid) begin
          ld_we_d   = 1'b1;
          ld_addr_d = ld_rev;
          ld_cnt_d  = ld_cnt_q + ONE;
          if (ld_cnt_q == LAST_SAMPLE) begin
            state_d  = S_COMPUTE;
            ld_cnt_d = '0;
            stage_d  = '0;
            bfly_d   = '0;
          end
        end
      end

      S_COMPUTE: begin
        rd_en_d = 1'b1;
        i1_d    = bf_i1;
        i2_d    = bf_i1 + span;
        tw_d    = tw_full[TW_W-1:0];
        bfly_d  = bfly_q + ONE;
        if (bfly_q == LAST_BFLY) begin
          state_d = S_DRAIN;
          bfly_d  = '0;
          drain_d = '0;
        end
      end

      S_DRAIN: begin
        drain_d = drain_q + DW'(1);
        if (drain_q == LAST_DRAIN) begin
          drain_d = '0;
          if (stage_q == LAST_STAGE) begin
            state_d     = S_UNLOAD;
            out_addr_d  = '0;
            fft_valid_d = 1'b1;
          end else begin
            state_d = S_COMPUTE;
            stage_d = stage_q + 4'd1;
          end
        end
      end

      S_UNLOAD: begin
        fft_valid_d = 1'b1;
        if (out_ready) begin
          if (out_addr_q == LAST_SAMPLE) begin
            state_d     = S_IDLE;
            fft_valid_d = 1'b0;
            done_d      = 1'b1;
            out_addr_d  = '0;
            stage_d     = '0;
          end else begin
            out_addr_d = out_addr_q + ONE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Registered from the next state so busy drops in the same cycle done rises.
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ld_cnt_q    <= '0;
      bfly_q      <= '0;
      drain_q     <= '0;
      stage_q     <= '0;
      ld_we_q     <= 1'b0;
      ld_addr_q   <= '0;
      rd_en_q     <= 1'b0;
      i1_q        <= '0;
      i2_q        <= '0;
      tw_q        <= '0;
      fft_valid_q <= 1'b0;
      out_addr_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ld_cnt_q    <= ld_cnt_d;
      bfly_q      <= bfly_d;
      drain_q     <= drain_d;
      stage_q     <= stage_d;
      ld_we_q     <= ld_we_d;
      ld_addr_q   <= ld_addr_d;
      rd_en_q     <= rd_en_d;
      i1_q        <= i1_d;
      i2_q        <= i2_d;
      tw_q        <= tw_d;
      fft_valid_q <= fft_valid_d;
      out_addr_q  <= out_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Reset flushes the pipe so no write-back of an aborted frame reaches the RAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < BFLY_LAT; k++) begin
        pipe_en_q[k] <= 1'b0;
        pipe_i1_q[k] <= '0;
        pipe_i2_q[k] <= '0;
      end
    end else begin
      pipe_en_q[0] <= rd_en_q;
      pipe_i1_q[0] <= i1_q;
      pipe_i2_q[0] <= i2_q;
      for (int k = 1; k < BFLY_LAT; k++) begin
        pipe_en_q[k] <= pipe_en_q[k-1];
        pipe_i1_q[k] <= pipe_i1_q[k-1];
        pipe_i2_q[k] <= pipe_i2_q[k-1];
      end
    end
  end

  assign ld_we     = ld_we_q;
  assign ld_addr   = ld_addr_q;
  assign rd_en     = rd_en_q;
  assign i1        = i1_q;
  assign i2        = i2_q;
  assign tw_idx    = tw_q;
  assign wr_en     = pipe_en_q[BFLY_LAT-1];
  assign wr_i1     = pipe_i1_q[BFLY_LAT-1];
  assign wr_i2     = pipe_i2_q[BFLY_LAT-1];
  assign stage_o   = stage_q;
  assign fft_valid = fft_valid_q;
  assign out_addr  = out_addr_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_fft_addr_sequencer.sv
// tb_fft_addr_sequencer
//   Directed bench for fft_addr_sequencer with N=256, BFLY_LAT=3.
//   A negedge monitor checks every load, read, write-back and output transfer;
//   the main process drives the frames and checks reset, handshake and totals.

module tb_fft_addr_sequencer;

  localparam int N_LOG2   = 8;
  localparam int BFLY_LAT = 3;
  localparam int N        = 256;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       ld_we;
  logic [7:0] ld_addr;
  logic       rd_en;
  logic [7:0] i1;
  logic [7:0] i2;
  logic [6:0] tw_idx;
  logic       wr_en;
  logic [7:0] wr_i1;
  logic [7:0] wr_i2;
  logic [3:0] stage_o;
  logic       fft_valid;
  logic [7:0] out_addr;
  logic       busy;
  logic       done;

  fft_addr_sequencer #(.N_LOG2(N_LOG2), .BFLY_LAT(BFLY_LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .ld_we     (ld_we),
    .ld_addr   (ld_addr),
    .rd_en     (rd_en),
    .i1        (i1),
    .i2        (i2),
    .tw_idx    (tw_idx),
    .wr_en     (wr_en),
    .wr_i1     (wr_i1),
    .wr_i2     (wr_i2),
    .stage_o   (stage_o),
    .out_ready (out_ready),
    .fft_valid (fft_valid),
    .out_addr  (out_addr),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] bitrev(input int v);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = v[7-k];
    return r;
  endfunction

  // ---------------- monitor ----------------
  int  cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit         mon_en = 1'b0;
  logic       hist_en [8];
  logic [7:0] hist_i1 [8];
  logic [7:0] hist_i2 [8];
  int  ld_seen = 0, rd_seen = 0, wr_seen = 0, out_seen = 0, done_seen = 0;
  int  last_rd_cyc = 0, last_wr_cyc = 0;
  int  st, bi;
  bit  prev_rd = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (ld_we) begin
        check_eq("ld_addr", ld_addr, bitrev(ld_seen));
        ld_seen++;
      end
      if (rd_en) begin
        st = rd_seen / 128;
        bi = rd_seen % 128;
        if (!prev_rd) begin
          check_eq("stage_start_b", bi, 0);
          check_eq("stage_o", stage_o, st);
          if (rd_seen > 0) begin
            check_eq("drain_gap", cyc - last_rd_cyc - 1, BFLY_LAT);
            check_eq("raw_margin", cyc - last_wr_cyc, 1);
          end
        end
        check_eq("i2_minus_i1", i2 - i1, 1 << st);
        if (st == 0 && bi == 0) begin
          check_eq("s0b0_i1", i1, 0); check_eq("s0b0_i2", i2, 1); check_eq("s0b0_tw", tw_idx, 0);
        end
        if (st == 1 && bi == 3) begin
          check_eq("s1b3_i1", i1, 5); check_eq("s1b3_i2", i2, 7); check_eq("s1b3_tw", tw_idx, 64);
        end
        if (st == 2 && bi == 6) begin
          check_eq("s2b6_i1", i1, 10); check_eq("s2b6_i2", i2, 14); check_eq("s2b6_tw", tw_idx, 64);
        end
        if (st == 3 && bi == 9) begin
          check_eq("s3b9_i1", i1, 17); check_eq("s3b9_i2", i2, 25); check_eq("s3b9_tw", tw_idx, 16);
        end
        if (st == 7 && bi == 5) begin
          check_eq("s7b5_i1", i1, 5); check_eq("s7b5_i2", i2, 133); check_eq("s7b5_tw", tw_idx, 5);
        end
        if (st == 7 && bi == 127) begin
          check_eq("s7b127_i1", i1, 127); check_eq("s7b127_i2", i2, 255); check_eq("s7b127_tw", tw_idx, 127);
        end
        last_rd_cyc = cyc;
        rd_seen++;
      end
      if (cyc >= BFLY_LAT) begin
        if (wr_en || hist_en[(cyc - BFLY_LAT) % 8]) begin
          check_eq("wr_en", wr_en, hist_en[(cyc - BFLY_LAT) % 8]);
          check_eq("wr_i1", wr_i1, hist_i1[(cyc - BFLY_LAT) % 8]);
          check_eq("wr_i2", wr_i2, hist_i2[(cyc - BFLY_LAT) % 8]);
        end
      end
      if (wr_en) begin
        wr_seen++;
        last_wr_cyc = cyc;
      end
      if (fft_valid && out_ready) begin
        check_eq("out_addr", out_addr, out_seen);
        out_seen++;
      end
      if (done) begin
        done_seen++;
        check_eq("done_after_last", out_seen, N);
        check_eq("busy_at_done", busy, 0);
        check_eq("valid_at_done", fft_valid, 0);
      end
    end
    prev_rd = rd_en;
    hist_en[cyc % 8] = rd_en;
    hist_i1[cyc % 8] = i1;
    hist_i2[cyc % 8] = i2;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string phase);
    check_eq({phase, "_busy"}, busy, 0);
    check_eq({phase, "_ld_we"}, ld_we, 0);
    check_eq({phase, "_ld_addr"}, ld_addr, 0);
    check_eq({phase, "_rd_en"}, rd_en, 0);
    check_eq({phase, "_i1"}, i1, 0);
    check_eq({phase, "_i2"}, i2, 0);
    check_eq({phase, "_tw"}, tw_idx, 0);
    check_eq({phase, "_wr_en"}, wr_en, 0);
    check_eq({phase, "_wr_i1"}, wr_i1, 0);
    check_eq({phase, "_stage"}, stage_o, 0);
    check_eq({phase, "_valid"}, fft_valid, 0);
    check_eq({phase, "_out_addr"}, out_addr, 0);
    check_eq({phase, "_done"}, done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int wr_hits;
    int gap_len;

    // Power-on reset
    reset = 1'b1;
    repeat (3) tick();
    check_all_zero("por");
    reset  = 1'b0;
    mon_en = 1'b1;
    $display("T1a power-on reset checked at cycle %0d", cyc);

    // in_valid in IDLE must not load anything
    in_valid = 1'b1;
    tick(); tick();
    in_valid = 1'b0;
    check_eq("idle_in_valid_ld_we", ld_we, 0);
    check_eq("idle_busy", busy, 0);

    // Frame 1: load with five gaps
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("start_busy", busy, 1);
    for (int i = 0; i < N; i++) begin
      if (i == 7 || i == 64 || i == 129 || i == 200 || i == 254) begin
        in_valid = 1'b0;
        gap_len  = (i % 3) + 1;
        repeat (gap_len) tick();
      end
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    $display("T2 load phase driven, %0d ld_we seen so far", ld_seen);

    // start during COMPUTE must be ignored
    repeat (10) tick();
    start = 1'b1;
    tick();
    start = 1'b0;

    ok = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      tick();
      if (fft_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("wait_unload", ok, 1);
    $display("T3/T4 compute phase ended at cycle %0d, rd=%0d wr=%0d", cyc, rd_seen, wr_seen);

    // Backpressure: hold, then toggle out_ready
    repeat (3) tick();
    check_eq("hold_valid", fft_valid, 1);
    check_eq("hold_addr", out_addr, 0);
    ok = 1'b0;
    for (int k = 0; k < 1200; k++) begin
      out_ready = (k % 2 == 0);
      tick();
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    out_ready = 1'b0;
    check_eq("wait_done", ok, 1);
    check_eq("busy_low_with_done", busy, 0);

    // New start in the cycle done is high is honoured next cycle
    start = 1'b1;
    mon_en = 1'b1;
    tick();
    start = 1'b0;
    check_eq("restart_busy", busy, 1);
    check_eq("done_one_cycle", done, 0);
    check_eq("total_ld_we", ld_seen, N);
    check_eq("total_rd_en", rd_seen, 1024);
    check_eq("total_wr_en", wr_seen, 1024);
    check_eq("total_out", out_seen, N);
    check_eq("done_pulses", done_seen, 1);
    $display("T5 unload finished: out=%0d done=%0d", out_seen, done_seen);
    mon_en = 1'b0;

    // Frame 2: abort with reset in the middle of COMPUTE
    in_valid = 1'b1;
    repeat (N) tick();
    in_valid = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (rd_en) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("frame2_compute", ok, 1);
    repeat (20) tick();
    check_eq("pre_reset_wr_en", wr_en, 1);
    reset = 1'b1;
    tick();
    check_all_zero("mid_reset");
    tick(); tick();
    reset = 1'b0;
    wr_hits = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (wr_en || busy || done || rd_en) wr_hits++;
    end
    check_eq("activity_after_reset", wr_hits, 0);
    $display("T1b mid-compute reset checked at cycle %0d", cyc);

    // Frame 3: sequencer recovers after reset
    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    tick();
    check_eq("f3_ld_we0", ld_we, 1);
    check_eq("f3_ld_addr0", ld_addr, 0);
    tick();
    check_eq("f3_ld_addr1", ld_addr, 128);
    tick();
    check_eq("f3_ld_addr2", ld_addr, 64);
    in_valid = 1'b0;
    tick();
    check_eq("f3_gap_ld_we", ld_we, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
